// File: rtl/demux_pkg.sv
// Shared defaults and route-select encoding for the 1:2 buffered demultiplexer.
package demux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 16;

    // Same polarity as the datapath 2:1 mux: select=1 picks the first output.
    localparam logic SEL_OUT0 = 1'b1;
    localparam logic SEL_OUT1 = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, synchronous flush and a zeroed head when empty.
module sync_fifo
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = empty_o ? '0 : mem_q[rptr_q];

    // Flush wins over everything; a pop on an empty FIFO is ignored.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/demux12_buf.sv
// 1:2 demultiplexer feeding two independent output FIFOs, with per-output accept counters.
module demux12_buf
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             flush,
    output logic             o0_valid,
    input  logic             o0_ready,
    output logic [WIDTH-1:0] o0_data,
    output logic             o1_valid,
    input  logic             o1_ready,
    output logic [WIDTH-1:0] o1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic             full0, full1, empty0, empty1;
    logic             accept, push0, push1;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Readiness looks only at the FIFO the current select points to, never at in_valid.
    assign in_ready = !flush && !((in_sel == SEL_OUT0) ? full0 : full1);
    assign accept   = in_valid && in_ready;
    assign push0    = accept && (in_sel == SEL_OUT0);
    assign push1    = accept && (in_sel == SEL_OUT1);

    assign o0_valid = !empty0;
    assign o1_valid = !empty1;
    assign cnt0     = cnt0_q;
    assign cnt1     = cnt1_q;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push0),
        .pop_i   (o0_ready),
        .flush_i (flush),
        .wdata_i (in_data),
        .full_o  (full0),
        .empty_o (empty0),
        .head_o  (o0_data)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push1),
        .pop_i   (o1_ready),
        .flush_i (flush),
        .wdata_i (in_data),
        .full_o  (full1),
        .empty_o (empty1),
        .head_o  (o1_data)
    );

    // Counters wrap naturally at 2^CNT_W; flush clears them alongside the FIFOs.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (flush) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (push0) cnt0_d = cnt0_q + 1'b1;
            if (push1) cnt1_d = cnt1_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

endmodule

// File: tb/tb_demux12_buf.sv
// Directed and randomized checks of demux12_buf against a queue-based model of its behaviour.
module tb_demux12_buf;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam int CNT_MOD = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_sel, flush, o0_ready, o1_ready;
    logic             in_ready, o0_valid, o1_valid;
    logic [WIDTH-1:0] in_data, o0_data, o1_data;
    logic [CNT_W-1:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;
    bit doChecks = 1'b1;

    // Reference model: one queue per output plus plain integer accept counts.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int c0 = 0;
    int c1 = 0;

    always #5 clk = ~clk;

    demux12_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .flush    (flush),
        .o0_valid (o0_valid),
        .o0_ready (o0_ready),
        .o0_data  (o0_data),
        .o1_valid (o1_valid),
        .o1_ready (o1_ready),
        .o1_data  (o1_data),
        .cnt0     (cnt0),
        .cnt1     (cnt1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkState();
        checkOutput("o0_valid", {31'b0, o0_valid}, {31'b0, q0.size() != 0});
        checkOutput("o0_data", o0_data, (q0.size() != 0) ? q0[0] : 32'h0);
        checkOutput("o1_valid", {31'b0, o1_valid}, {31'b0, q1.size() != 0});
        checkOutput("o1_data", o1_data, (q1.size() != 0) ? q1[0] : 32'h0);
        checkOutput("cnt0", {16'b0, cnt0}, 32'(c0));
        checkOutput("cnt1", {16'b0, cnt1}, 32'(c1));
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic s,
                                 input logic r0, input logic r1, input logic f);
        logic expReady;
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        o0_ready = r0;
        o1_ready = r1;
        flush    = f;
        @(negedge clk);
        expReady = !f && ((s ? q0.size() : q1.size()) < DEPTH);
        if (doChecks) checkOutput("in_ready", {31'b0, in_ready}, {31'b0, expReady});
        if (f) begin
            q0.delete();
            q1.delete();
            c0 = 0;
            c1 = 0;
        end else begin
            if (r0 && q0.size() != 0) void'(q0.pop_front());
            if (r1 && q1.size() != 0) void'(q1.pop_front());
            if (v && expReady) begin
                if (s) begin
                    q0.push_back(d);
                    c0 = (c0 + 1) % CNT_MOD;
                end else begin
                    q1.push_back(d);
                    c1 = (c1 + 1) % CNT_MOD;
                end
            end
        end
        @(posedge clk);
        #1;
        if (doChecks) checkState();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_sel   = 1'b1;
        flush    = 1'b0;
        o0_ready = 1'b0;
        o1_ready = 1'b0;
        #12;
        checkOutput("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkState();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Single word to output 0.
        applyStimulus(1, 100, 1, 0, 0, 0);
        checkOutput("first_o0_data", o0_data, 32'd100);
        checkOutput("first_cnt0", {16'b0, cnt0}, 32'd1);

        // Single word to output 1 with the consumer ready: visible one cycle, then gone.
        applyStimulus(1, 2, 0, 0, 1, 0);
        checkOutput("o1_shows_2", o1_data, 32'd2);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("o1_drained", {31'b0, o1_valid}, 32'd0);
        checkOutput("cnt1_one", {16'b0, cnt1}, 32'd1);

        // Stall output 0, overfill it, keep output 1 flowing, then drain in order.
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(1, 11, 1, 0, 0, 0);
        applyStimulus(1, 12, 1, 0, 0, 0);
        applyStimulus(1, 13, 1, 0, 0, 0);
        checkOutput("full_refuses", {31'b0, in_ready}, 32'd0);
        applyStimulus(1, 21, 0, 0, 0, 0);
        checkOutput("other_side_ok", o1_data, 32'd21);
        checkOutput("order_head", o0_data, 32'd11);
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("order_next", o0_data, 32'd12);
        applyStimulus(0, 0, 1, 1, 1, 0);

        // Full FIFO popped and pushed in the same cycle: push refused, occupancy drops to one.
        applyStimulus(1, 31, 1, 0, 0, 0);
        applyStimulus(1, 32, 1, 0, 0, 0);
        applyStimulus(1, 33, 1, 1, 0, 0);
        checkOutput("pop_while_full", o0_data, 32'd32);
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("occupancy_one", {31'b0, o0_valid}, 32'd0);

        // Counter wrap: clear, accept 65535 words, then one more.
        applyStimulus(0, 0, 1, 0, 0, 1);
        doChecks = 1'b0;
        for (int i = 0; i < CNT_MOD - 1; i++) applyStimulus(1, 32'(i), 1, 1, 0, 0);
        doChecks = 1'b1;
        checkOutput("cnt0_max", {16'b0, cnt0}, 32'd65535);
        applyStimulus(1, 32'hABCD, 1, 1, 0, 0);
        checkOutput("cnt0_wrap", {16'b0, cnt0}, 32'd0);

        // Flush with data queued on both sides.
        applyStimulus(1, 41, 0, 0, 0, 0);
        applyStimulus(1, 42, 1, 0, 0, 0);
        applyStimulus(1, 43, 1, 1, 1, 1);
        checkOutput("flush_o0_valid", {31'b0, o0_valid}, 32'd0);
        checkOutput("flush_o1_valid", {31'b0, o1_valid}, 32'd0);
        checkOutput("flush_cnt1", {16'b0, cnt1}, 32'd0);

        // Asynchronous reset between edges while words are stored.
        applyStimulus(1, 51, 1, 0, 0, 0);
        applyStimulus(1, 52, 0, 0, 0, 0);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        c0 = 0;
        c1 = 0;
        checkState();
        checkOutput("reset_mid_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkState();
        applyStimulus(0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 24) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux12_buf.md
DEMUX12_BUF -- requirements
Module: demux12_buf

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits.
REQ-002 Parameter DEPTH, default 2, entries per output FIFO (power of two, >=2).
REQ-003 Parameter CNT_W, default 16, width of per-output accept counters.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream word present.
REQ-007 in_ready  output  1  block accepts word this cycle.
REQ-008 in_data  input  WIDTH  upstream word.
REQ-009 in_sel  input  1  route select; 1 -> output 0, 0 -> output 1 (same polarity as the datapath 2:1 mux: select=1 picks d0).
REQ-010 flush  input  1  synchronous clear of both FIFOs.
REQ-011 o0_valid / o1_valid  output  1  each output FIFO non-empty.
REQ-012 o0_ready / o1_ready  input  1  each downstream consumer ready.
REQ-013 o0_data / o1_data  output  WIDTH  head entry of each FIFO; 0 when empty.
REQ-014 cnt0 / cnt1  output  CNT_W  words accepted toward each output since reset/flush.

Function
REQ-015 Accept occurs when in_valid && in_ready; the word is pushed into FIFO0 if in_sel=1, else FIFO1.
REQ-016 in_ready SHALL be combinational: !flush && !full of the FIFO selected by the current in_sel; no dependency on in_valid.
REQ-017 No bypass: an accepted word appears at oN_data with oN_valid=1 exactly one cycle after acceptance, at the earliest.
REQ-018 Pop from FIFO N occurs when oN_valid && oN_ready; oN_data then advances to the next entry.
REQ-019 Push and pop on the same FIFO in one cycle SHALL both take effect; occupancy unchanged.
REQ-020 Full FIFO: in_ready=0 for that select even when the FIFO is popped that same cycle.
REQ-021 Empty FIFO: oN_valid=0, oN_data=0, oN_ready ignored.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; occupancy tracked in log2(DEPTH)+1 bits.
REQ-023 FIFOs and routing SHALL be independent: a stalled output never blocks traffic to the other output.
REQ-024 cntN increments by 1 on each accept toward output N and wraps from 2^CNT_W-1 to 0.
REQ-025 flush=1: both FIFOs emptied and both counters cleared at the next edge; pushes and pops in that cycle are discarded; in_ready=0 while flush=1.
REQ-026 Word order per output SHALL equal acceptance order.

Reset
REQ-027 rst_n low SHALL immediately empty both FIFOs, clear pointers and counters: o0_valid=o1_valid=0, o0_data=o1_data=0, cnt0=cnt1=0.
REQ-028 in_ready SHALL read 1 during and after reset (FIFOs empty, flush low).
REQ-029 Reset asserted mid-transfer SHALL discard all stored words; no partial output after release.

Structure
REQ-030 Package demux_pkg holds WIDTH, DEPTH, and CNT_W defaults plus the select-encoding constants SEL_OUT0=1 and SEL_OUT1=0.
REQ-031 One sub-module sync_fifo (WIDTH, DEPTH; push, pop, flush, full, empty, head) SHALL be instantiated twice.
REQ-032 Top level contains only the routing logic, in_ready generation, and the counters.

Verification
REQ-033 Reset, then send 100 with in_sel=1 -> next cycle o0_valid=1, o0_data=100, o1_valid=0, cnt0=1, cnt1=0.
REQ-034 Send 2 with in_sel=0 while o1_ready=1 -> o1_data=2 for one cycle, then o1_valid=0; cnt1=1.
REQ-035 Hold o0_ready=0 and push 3 words to output 0 (DEPTH=2) -> in_ready=0 after 2 accepts; with in_sel=0, output 1 still accepts; releasing o0_ready drains 2 words in order.
REQ-036 Full FIFO0, assert o0_ready and push simultaneously -> pop occurs, push refused (in_ready=0), occupancy becomes 1.
REQ-037 Set cnt0 to 65535 via accepts, then accept 1 more -> cnt0=0; assert flush with data queued -> both valids 0 and counters 0 at the next edge.
REQ-038 Assert rst_n=0 mid-stream (asynchronous, between edges) -> outputs clear immediately; after release, no stale word appears.
